fpu_arbiter: RTL and testbench
==============================

FPU_ARBITER -- requirements
Module: fpu_arbiter

Interface
REQ-001 SHALL have parameter FPU_LAT, default 4: cycles from operands stable on fpu_*_o to valid fpu_result_i; legal range 1..255.
REQ-002 SHALL have port clk_i  in  1  single clock, all logic on rising edge.
REQ-003 SHALL have port RST  in  1  synchronous reset, active-high.
REQ-004 SHALL have port req_valid_i  in  2  per-requester request valid, bit n = requester n.
REQ-005 SHALL have port req_ready_o  out  2  per-requester accept.
REQ-006 SHALL have port req_opa_i  in  64  operand A, requester n on bits [32n+31:32n].
REQ-007 SHALL have port req_opb_i  in  64  operand B, same packing.
REQ-008 SHALL have port req_op_i  in  2  per-requester op, 0 add, 1 sub.
REQ-009 SHALL have port req_mode_i  in  4  per-requester rounding mode, bits [2n+1:2n].
REQ-010 SHALL have port rsp_valid_o  out  1  response valid.
REQ-011 SHALL have port rsp_ready_i  in  1  response accept.
REQ-012 SHALL have port rsp_id_o  out  1  index of the requester owning the response.
REQ-013 SHALL have port rsp_result_o  out  32  IEEE-754 single result.
REQ-014 SHALL have port rsp_flags_o  out  5  {ine, overflow, underflow, inf, zero}.
REQ-015 SHALL have ports fpu_opa_o, fpu_opb_o  out  32 each; fpu_op_o  out  1; fpu_mode_o  out  2: registered drive to the FPU.
REQ-016 SHALL have ports fpu_result_i  in  32 and fpu_flags_i  in  5: FPU outputs, same flag order as rsp_flags_o.
REQ-017 SHALL have port busy_o  out  1  high whenever state is not IDLE.

Function
REQ-018 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE.
REQ-019 IDLE: grant = the only valid requester; if both are valid, the requester not granted last; req_ready_o is one-hot at the grant and 0 when no request is valid.
REQ-020 Acceptance at cycle T (valid & ready) SHALL register the granted operands, op, mode and id, load the counter with FPU_LAT-1, update the last-granted pointer and enter WAIT.
REQ-021 fpu_*_o SHALL change only on acceptance and SHALL hold steady through WAIT and RESP.
REQ-022 WAIT SHALL last exactly FPU_LAT cycles; on its last cycle, fpu_result_i and fpu_flags_i SHALL be captured into the response registers and the FSM SHALL enter RESP.
REQ-023 rsp_valid_o SHALL assert in cycle T+1+FPU_LAT and hold, with rsp_* stable, until rsp_ready_i is high; it SHALL then return to IDLE on the next cycle.
REQ-024 req_ready_o SHALL be 2'b00 in WAIT and RESP, so there is no back-to-back accept in the RESP handshake cycle and minimum issue spacing is FPU_LAT+2 cycles.
REQ-025 A requester dropping valid before acceptance SHALL leave no state change; an acceptance with FPU_LAT=1 SHALL spend one cycle in WAIT.

Reset
REQ-026 RST SHALL force IDLE, counter 0, last-granted pointer = 1 (requester 0 wins the first tie), and all outputs 0 (including rsp_valid_o, req_ready_o, fpu_*_o, busy_o) on the next edge.
REQ-027 RST asserted in WAIT or RESP SHALL abandon the operation with no response issued; RST SHALL dominate a simultaneous handshake.

Configuration
REQ-028 Macro FPU_ARB_FLAGS_EN defined: rsp_flags_o SHALL carry the captured fpu_flags_i.
REQ-029 Macro FPU_ARB_FLAGS_EN undefined: no flag registers SHALL exist, rsp_flags_o SHALL be constant 5'b0, and fpu_flags_i SHALL be ignored.

Verification
REQ-030 Req0 only: 3F800000 + 3F800000, op 0, FPU_LAT=4 -> ready at T, rsp_valid at T+5, result 40000000, id 0.
REQ-031 Both valid, same cycle after reset: req0 40400000 - 3F800000, req1 40200000 + 40200000 -> req0 served first (40000000), then req1 (40A00000, id 1); with both held continuously, grants alternate 0,1,0,1.
REQ-032 rsp_ready_i held low 10 cycles in RESP -> rsp_valid and rsp_result stay stable, req_ready_o stays 00, fpu_*_o unchanged.
REQ-033 RST asserted in the 2nd WAIT cycle -> no rsp_valid; all outputs 0 next cycle; next tie grants requester 0.
REQ-034 41200000 - 41200000 -> result 00000000; rsp_flags_o = 00001 with FPU_ARB_FLAGS_EN defined, 00000 without.
REQ-035 FPU_LAT=1, back-to-back requests from req1 only -> accepts spaced exactly 3 cycles when rsp_ready_i is tied high.

Source files
------------

// File: rtl/fpu_arbiter.sv
// Two-requester round-robin front end for a fixed-latency single-precision FPU.
// Optional macro FPU_ARB_FLAGS_EN: capture fpu_flags_i into rsp_flags_o (otherwise tied to zero).
module fpu_arbiter #(
  parameter int unsigned FPU_LAT = 4
) (
  input  logic        clk_i,
  input  logic        RST,
  input  logic [1:0]  req_valid_i,
  output logic [1:0]  req_ready_o,
  input  logic [63:0] req_opa_i,
  input  logic [63:0] req_opb_i,
  input  logic [1:0]  req_op_i,
  input  logic [3:0]  req_mode_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic        rsp_id_o,
  output logic [31:0] rsp_result_o,
  output logic [4:0]  rsp_flags_o,
  output logic [31:0] fpu_opa_o,
  output logic [31:0] fpu_opb_o,
  output logic        fpu_op_o,
  output logic [1:0]  fpu_mode_o,
  input  logic [31:0] fpu_result_i,
  input  logic [4:0]  fpu_flags_i,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [7:0] CNT_INIT = 8'(FPU_LAT - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_cnt;
  logic        r_last;
  logic        r_id;
  logic [31:0] r_opa;
  logic [31:0] r_opb;
  logic        r_op;
  logic [1:0]  r_mode;
  logic [31:0] r_result;

  logic        w_gnt;
  logic [1:0]  w_ready;
  logic        w_accept;
  logic        w_wait_done;

  // Ready is withheld while RST is high so reset always dominates a handshake.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first; a path
    // that leaves one unassigned would infer a latch.
    w_gnt   = 1'b0;
    w_ready = 2'b00;
    if (req_valid_i == 2'b11) begin
      w_gnt = ~r_last;
    end else begin
      w_gnt = req_valid_i[1];
    end
    if ((r_state == S_IDLE) && !RST && (req_valid_i != 2'b00)) begin
      w_ready = w_gnt ? 2'b10 : 2'b01;
    end
  end

  assign w_accept    = |(w_ready & req_valid_i);
  assign w_wait_done = (r_state == S_WAIT) && (r_cnt == 8'd0);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)    w_state_nxt = S_WAIT;
      S_WAIT:  if (w_wait_done) w_state_nxt = S_RESP;
      S_RESP:  if (rsp_ready_i) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (RST) begin
      // NOTE: every register here is control or a visible output, so all of
      // them are reset; there is no storage array that could be left unreset.
      r_state  <= S_IDLE;
      r_cnt    <= 8'd0;
      r_last   <= 1'b1;
      r_id     <= 1'b0;
      r_opa    <= 32'd0;
      r_opb    <= 32'd0;
      r_op     <= 1'b0;
      r_mode   <= 2'b00;
      r_result <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_opa  <= w_gnt ? req_opa_i[63:32] : req_opa_i[31:0];
        r_opb  <= w_gnt ? req_opb_i[63:32] : req_opb_i[31:0];
        r_op   <= req_op_i[w_gnt];
        r_mode <= w_gnt ? req_mode_i[3:2] : req_mode_i[1:0];
        r_id   <= w_gnt;
        r_last <= w_gnt;
        r_cnt  <= CNT_INIT;
      end else if ((r_state == S_WAIT) && (r_cnt != 8'd0)) begin
        r_cnt <= r_cnt - 8'd1;
      end
      if (w_wait_done) begin
        r_result <= fpu_result_i;
      end
    end
  end

`ifdef FPU_ARB_FLAGS_EN
  logic [4:0] r_flags;

  always_ff @(posedge clk_i) begin
    if (RST) begin
      r_flags <= 5'd0;
    end else if (w_wait_done) begin
      r_flags <= fpu_flags_i;
    end
  end

  assign rsp_flags_o = r_flags;
`else
  logic w_unused_flags;

  assign w_unused_flags = ^fpu_flags_i;
  assign rsp_flags_o    = 5'd0;
`endif

  assign req_ready_o  = w_ready;
  assign rsp_valid_o  = (r_state == S_RESP);
  assign rsp_id_o     = r_id;
  assign rsp_result_o = r_result;
  assign fpu_opa_o    = r_opa;
  assign fpu_opb_o    = r_opb;
  assign fpu_op_o     = r_op;
  assign fpu_mode_o   = r_mode;
  assign busy_o       = (r_state != S_IDLE);

endmodule

// File: tb/tb_fpu_arbiter.sv
// Scoreboard bench for fpu_arbiter: directed vectors against a lookup-table FPU,
// plus a second FPU_LAT=1 instance checking minimum issue spacing.
module tb_fpu_arbiter;

  localparam int LAT = 4;
`ifdef FPU_ARB_FLAGS_EN
  localparam bit FLAGS_ON = 1'b1;
`else
  localparam bit FLAGS_ON = 1'b0;
`endif

  typedef struct {
    logic        id;
    logic [31:0] res;
    logic [4:0]  flg;
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [1:0]  md;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [63:0] req_opa = '0;
  logic [63:0] req_opb = '0;
  logic [1:0]  req_op = '0;
  logic [3:0]  req_mode = '0;
  logic        rsp_valid;
  logic        rsp_rdy = 1'b1;
  logic        rsp_id;
  logic [31:0] rsp_result;
  logic [4:0]  rsp_flags;
  logic [31:0] fpu_opa, fpu_opb, fpu_result;
  logic        fpu_op;
  logic [1:0]  fpu_mode;
  logic [4:0]  fpu_flags;
  logic        busy;

  logic        rst1 = 1'b1;
  logic [1:0]  d1_valid = 2'b00;
  logic [1:0]  d1_ready;
  logic        d1_rsp_valid, d1_rsp_id, d1_op;
  logic [31:0] d1_rsp_result, d1_opa, d1_opb, d1_result;
  logic [4:0]  d1_rsp_flags, d1_flags;
  logic [1:0]  d1_mode;
  logic        d1_busy;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t q[$];
  logic [31:0] exp_res [2];
  logic [4:0]  exp_flg [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in FPU: hand-computed results for the directed vectors; anything else
  // yields a recognisable wrong answer with the inexact flag set.
  function automatic logic [36:0] fpu_model(logic [31:0] a, logic [31:0] b, logic op);
    case ({op, a, b})
      {1'b0, 32'h3F800000, 32'h3F800000}: return {5'b00000, 32'h40000000};
      {1'b1, 32'h40400000, 32'h3F800000}: return {5'b00000, 32'h40000000};
      {1'b0, 32'h40200000, 32'h40200000}: return {5'b00000, 32'h40A00000};
      {1'b1, 32'h41200000, 32'h41200000}: return {5'b00001, 32'h00000000};
      default:                            return {5'b10000, a - b};
    endcase
  endfunction

  assign {fpu_flags, fpu_result} = fpu_model(fpu_opa, fpu_opb, fpu_op);
  assign {d1_flags, d1_result}   = fpu_model(d1_opa, d1_opb, d1_op);

  fpu_arbiter #(.FPU_LAT(LAT)) u_dut (
    .clk_i(clk), .RST(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_opa_i(req_opa), .req_opb_i(req_opb), .req_op_i(req_op), .req_mode_i(req_mode),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_rdy), .rsp_id_o(rsp_id),
    .rsp_result_o(rsp_result), .rsp_flags_o(rsp_flags),
    .fpu_opa_o(fpu_opa), .fpu_opb_o(fpu_opb), .fpu_op_o(fpu_op), .fpu_mode_o(fpu_mode),
    .fpu_result_i(fpu_result), .fpu_flags_i(fpu_flags), .busy_o(busy)
  );

  fpu_arbiter #(.FPU_LAT(1)) u_dut1 (
    .clk_i(clk), .RST(rst1),
    .req_valid_i(d1_valid), .req_ready_o(d1_ready),
    .req_opa_i({32'h3F800000, 32'h0}), .req_opb_i({32'h3F800000, 32'h0}),
    .req_op_i(2'b00), .req_mode_i(4'b1100),
    .rsp_valid_o(d1_rsp_valid), .rsp_ready_i(1'b1), .rsp_id_o(d1_rsp_id),
    .rsp_result_o(d1_rsp_result), .rsp_flags_o(d1_rsp_flags),
    .fpu_opa_o(d1_opa), .fpu_opb_o(d1_opb), .fpu_op_o(d1_op), .fpu_mode_o(d1_mode),
    .fpu_result_i(d1_result), .fpu_flags_i(d1_flags), .busy_o(d1_busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_req(input int n, input logic [31:0] a, input logic [31:0] b,
                         input logic op, input logic [1:0] md,
                         input logic [31:0] res, input logic [4:0] flg);
    req_opa[32*n +: 32] = a;
    req_opb[32*n +: 32] = b;
    req_op[n]           = op;
    req_mode[2*n +: 2]  = md;
    exp_res[n]          = res;
    exp_flg[n]          = flg;
  endtask

  // Waits for the grant, checks it is the expected one-hot and pushes the
  // expected response; returns just after the accepting edge.
  task automatic wait_accept(input int g);
    exp_t e;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (req_ready != 2'b00) begin
        check("grant", req_ready, 64'(2'b01 << g));
        e.id  = 1'(g);
        e.res = exp_res[g];
        e.flg = FLAGS_ON ? exp_flg[g] : 5'd0;
        e.a   = req_opa[32*g +: 32];
        e.b   = req_opb[32*g +: 32];
        e.op  = req_op[g];
        e.md  = req_mode[2*g +: 2];
        e.acc = cyc;
        q.push_back(e);
        @(posedge clk); #1;
        return;
      end
    end
    check("accept_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (q.size() == 0) begin
        @(posedge clk); #1;
        return;
      end
    end
    check("drain_timeout", 64'(q.size()), 0);
  endtask

  // Monitor: compares every cycle a response is presented against the queue head.
  initial begin : monitor
    bit   first = 1'b1;
    exp_t e;
    forever begin
      @(negedge clk);
      if (busy) check("ready_while_busy", req_ready, 0);
      if (rsp_valid) begin
        if (q.size() == 0) begin
          check("unexpected_rsp", 1, 0);
        end else begin
          e = q[0];
          if (first) check("rsp_latency", 64'(cyc - e.acc), 64'(LAT + 1));
          check("rsp_id", rsp_id, e.id);
          check("rsp_result", rsp_result, e.res);
          check("rsp_flags", rsp_flags, e.flg);
          check("fpu_opa", fpu_opa, e.a);
          check("fpu_opb", fpu_opb, e.b);
          check("fpu_op", fpu_op, e.op);
          check("fpu_mode", fpu_mode, e.md);
          check("busy_in_resp", busy, 1);
          if (rsp_rdy) void'(q.pop_front());
        end
      end
      first = !(rsp_valid && !rsp_rdy);
    end
  end

  initial begin : main
    int last_acc;
    int n_acc;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_fpu", {fpu_opa, fpu_op, fpu_mode}, 0);
    check("rst_rsp", {rsp_result, rsp_flags, rsp_id}, 0);
    @(posedge clk); #1;
    rst  = 1'b0;
    rst1 = 1'b0;

    // Simultaneous requests: req0 wins the first tie, then grants alternate.
    set_req(0, 32'h40400000, 32'h3F800000, 1'b1, 2'b01, 32'h40000000, 5'b00000);
    set_req(1, 32'h40200000, 32'h40200000, 1'b0, 2'b10, 32'h40A00000, 5'b00000);
    req_valid = 2'b11;
    wait_accept(0);
    wait_accept(1);
    wait_accept(0);
    wait_accept(1);
    req_valid = 2'b00;
    drain();

    // Single requester 0: 1.0 + 1.0.
    set_req(0, 32'h3F800000, 32'h3F800000, 1'b0, 2'b11, 32'h40000000, 5'b00000);
    req_valid = 2'b01;
    wait_accept(0);
    req_valid = 2'b00;
    drain();

    // Back-pressure for 10 cycles; 10.0 - 10.0 gives zero with the zero flag.
    rsp_rdy = 1'b0;
    set_req(1, 32'h41200000, 32'h41200000, 1'b1, 2'b01, 32'h00000000, 5'b00001);
    req_valid = 2'b10;
    wait_accept(1);
    req_valid = 2'b01;
    for (int k = 0; k < 40 && !rsp_valid; k++) @(negedge clk);
    check("rsp_seen", rsp_valid, 1);
    repeat (10) @(negedge clk);
    @(posedge clk); #1;
    rsp_rdy   = 1'b1;
    req_valid = 2'b00;
    drain();

    // Reset during the second WAIT cycle abandons the operation.
    set_req(0, 32'h40400000, 32'h3F800000, 1'b1, 2'b10, 32'h40000000, 5'b00000);
    req_valid = 2'b01;
    wait_accept(0);
    req_valid = 2'b00;
    @(posedge clk); #1;
    rst = 1'b1;
    q.delete();
    @(posedge clk); #1;
    check("abort_rsp_valid", rsp_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_ready", req_ready, 0);
    check("abort_fpu", {fpu_opa, fpu_opb, fpu_op, fpu_mode}, 0);
    check("abort_rsp", {rsp_result, rsp_flags, rsp_id}, 0);
    rst = 1'b0;
    req_valid = 2'b11;
    wait_accept(0);
    req_valid = 2'b00;
    drain();
    check("queue_empty", 64'(q.size()), 0);

    // FPU_LAT=1 instance, requester 1 held valid, response always accepted.
    d1_valid = 2'b10;
    last_acc = 0;
    n_acc    = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (d1_ready != 2'b00) begin
        check("d1_grant", d1_ready, 2'b10);
        if (n_acc > 0) check("d1_spacing", 64'(cyc - last_acc), 3);
        last_acc = cyc;
        n_acc++;
      end
      if (d1_rsp_valid) begin
        check("d1_result", d1_rsp_result, 32'h40000000);
        check("d1_id", d1_rsp_id, 1);
        check("d1_mode", d1_mode, 2'b11);
      end
    end
    check("d1_accept_count", 64'(n_acc >= 6), 1);
    d1_valid = 2'b00;
    repeat (4) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
